// File: rtl/mport_fifo_pkg.sv
// Shared constants and arithmetic helpers for the multi-port FIFO.
package mport_fifo_pkg;

    localparam int unsigned MAX_PORTS = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // Pointer advance modulo an arbitrary depth; ptr + k must stay below 2*depth.
    function automatic logic [7:0] wrap_add(input logic [7:0] ptr, input logic [3:0] k,
                                            input logic [8:0] depth);
        logic [8:0] sum;
        sum = {1'b0, ptr} + {5'b0, k};
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/mport_fifo_alloc.sv
// Ranks asserted requests in ascending port order and grants the first 'capacity' of them.
module mport_fifo_alloc
    import mport_fifo_pkg::*;
#(
    parameter int unsigned PORTS = 2,
    parameter int unsigned CW    = 5
) (
    input  logic [PORTS-1:0]      req_i,
    input  logic [CW-1:0]         cap_i,
    output logic [PORTS-1:0]      grant_o,
    output logic [PORTS-1:0]      fail_o,
    output logic [PORTS-1:0][2:0] rank_o,
    output logic [3:0]            acc_o
);

    always_comb begin
        logic [MAX_PORTS-1:0] req8;
        logic [3:0]           nreq;
        logic [3:0]           below;
        req8    = MAX_PORTS'(req_i);
        nreq    = popcount8(req8);
        acc_o   = (32'(nreq) < 32'(cap_i)) ? nreq : 4'(cap_i);
        grant_o = '0;
        fail_o  = '0;
        rank_o  = '0;
        below   = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            // rank = number of asserted requests on lower-indexed ports
            below      = popcount8(req8 & ((8'd1 << i) - 8'd1));
            rank_o[i]  = below[2:0];
            grant_o[i] = req_i[i] && (32'(below) < 32'(cap_i));
            fail_o[i]  = req_i[i] && !(32'(below) < 32'(cap_i));
        end
    end

endmodule

// File: rtl/mport_fifo.sv
// Multi-port synchronous FIFO: several writes and reads per cycle over one circular buffer.
module mport_fifo
    import mport_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WR_PORTS  = 2,
    parameter int unsigned RD_PORTS  = 2,
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic                               clk,
    input  logic                               srst,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]     din,
    input  logic [WR_PORTS-1:0]                wr_en,
    output logic [WR_PORTS-1:0]                wr_fail,
    input  logic [RD_PORTS-1:0]                rd_en,
    output logic [RD_PORTS-1:0][WIDTH-1:0]     dout,
    output logic [RD_PORTS-1:0]                rd_valid,
    output logic [RD_PORTS-1:0]                rd_fail,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic [$clog2(DEPTH+1)-1:0]         data_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] ram_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_w, avail_w;

    logic [WR_PORTS-1:0]      wr_grant, wr_fail_d, wr_fail_q;
    logic [WR_PORTS-1:0][2:0] wr_rank;
    logic [3:0]               wr_acc;
    logic [PW-1:0]            wr_addr [WR_PORTS];

    logic [RD_PORTS-1:0]            rd_grant, rd_fail_d, rd_fail_q, rd_valid_q;
    logic [RD_PORTS-1:0][2:0]       rd_rank;
    logic [3:0]                     rd_acc;
    logic [PW-1:0]                  rd_addr [RD_PORTS];
    logic [RD_PORTS-1:0][WIDTH-1:0] dout_q;

    mport_fifo_alloc #(.PORTS(WR_PORTS), .CW(CW)) u_wr_alloc (
        .req_i   (wr_en),
        .cap_i   (free_w),
        .grant_o (wr_grant),
        .fail_o  (wr_fail_d),
        .rank_o  (wr_rank),
        .acc_o   (wr_acc)
    );

    mport_fifo_alloc #(.PORTS(RD_PORTS), .CW(CW)) u_rd_alloc (
        .req_i   (rd_en),
        .cap_i   (avail_w),
        .grant_o (rd_grant),
        .fail_o  (rd_fail_d),
        .rank_o  (rd_rank),
        .acc_o   (rd_acc)
    );

    always_comb begin
        free_w  = CW'(DEPTH) - count_q;
        avail_w = count_q;
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            wr_addr[i] = PW'(wrap_add(8'(wr_ptr_q), {1'b0, wr_rank[i]}, 9'(DEPTH)));
        end
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            rd_addr[i] = PW'(wrap_add(8'(rd_ptr_q), {1'b0, rd_rank[i]}, 9'(DEPTH)));
        end
        wr_ptr_d = PW'(wrap_add(8'(wr_ptr_q), wr_acc, 9'(DEPTH)));
        rd_ptr_d = PW'(wrap_add(8'(rd_ptr_q), rd_acc, 9'(DEPTH)));
        // acc_w <= free keeps the partial sum within CW bits; acc_r <= count keeps it non-negative
        count_d  = (count_q + CW'(wr_acc)) - CW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_fail_q  <= '0;
            rd_fail_q  <= '0;
            rd_valid_q <= '0;
            dout_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_fail_q  <= wr_fail_d;
            rd_fail_q  <= rd_fail_d;
            rd_valid_q <= rd_grant;
            for (int unsigned i = 0; i < RD_PORTS; i++) begin
                if (rd_grant[i]) begin
                    dout_q[i] <= ram_q[rd_addr[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            if (!srst && wr_grant[i]) begin
                ram_q[wr_addr[i]] <= din[i];
            end
        end
    end

    assign wr_fail     = wr_fail_q;
    assign rd_fail     = rd_fail_q;
    assign rd_valid    = rd_valid_q;
    assign dout        = dout_q;
    assign data_count  = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (32'(count_q) >= 32'(AFULL_LVL));

endmodule

// File: tb/tb_mport_fifo.sv
// Directed vector table plus randomized traffic against a queue-based FIFO model.
module tb_mport_fifo;

    localparam int unsigned DEPTH = 6;

    logic            clk = 1'b0;
    logic            srst;
    logic [3:0][7:0] din;
    logic [3:0]      wr_en;
    logic [3:0]      wr_fail;
    logic [3:0]      rd_en;
    logic [3:0][7:0] dout;
    logic [3:0]      rd_valid;
    logic [3:0]      rd_fail;
    logic            full, empty, almost_full;
    logic [2:0]      data_count;

    mport_fifo #(
        .WIDTH     (8),
        .DEPTH     (DEPTH),
        .WR_PORTS  (4),
        .RD_PORTS  (4),
        .AFULL_LVL (4)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .din         (din),
        .wr_en       (wr_en),
        .wr_fail     (wr_fail),
        .rd_en       (rd_en),
        .dout        (dout),
        .rd_valid    (rd_valid),
        .rd_fail     (rd_fail),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .data_count  (data_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  we;
        logic [31:0] d;
        logic [3:0]  re;
        logic [3:0]  e_wf;
        logic [3:0]  e_rv;
        logic [3:0]  e_rf;
        logic [31:0] e_dout;
        logic [2:0]  e_cnt;
        logic [2:0]  e_flags;   // {full, almost_full, empty}
    } vec_t;

    vec_t tv[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]      mq[$];
    logic [3:0][7:0] m_dout;
    logic [3:0]      m_rv, m_rf, m_wf;

    task automatic add(input logic rst, input logic [3:0] we, input logic [31:0] d,
                       input logic [3:0] re, input logic [3:0] ewf, input logic [3:0] erv,
                       input logic [3:0] erf, input logic [31:0] edout, input logic [2:0] ecnt,
                       input logic [2:0] eflags);
        vec_t v;
        v.rst = rst; v.we = we; v.d = d; v.re = re;
        v.e_wf = ewf; v.e_rv = erv; v.e_rf = erf; v.e_dout = edout;
        v.e_cnt = ecnt; v.e_flags = eflags;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] we, input logic [31:0] d,
                         input logic [3:0] re);
        @(negedge clk);
        srst  = rst;
        wr_en = we;
        din   = d;
        rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] ewf, input logic [3:0] erv,
                                 input logic [3:0] erf, input logic [31:0] edout,
                                 input logic [2:0] ecnt, input logic [2:0] eflags);
        check({tag, " wr_fail"},    32'(wr_fail), 32'(ewf));
        check({tag, " rd_valid"},   32'(rd_valid), 32'(erv));
        check({tag, " rd_fail"},    32'(rd_fail), 32'(erf));
        check({tag, " dout"},       dout, edout);
        check({tag, " data_count"}, 32'(data_count), 32'(ecnt));
        check({tag, " flags"},      32'({full, almost_full, empty}), 32'(eflags));
    endtask

    // Reference: the FIFO is a queue; reads see only the words present before this cycle.
    task automatic model_step(input logic rst, input logic [3:0] we, input logic [31:0] d,
                              input logic [3:0] re);
        logic [3:0][7:0] dw;
        int unsigned avail, free, nr, nw;
        dw = d;
        m_wf = '0; m_rv = '0; m_rf = '0;
        if (rst) begin
            mq.delete();
            m_dout = '0;
            return;
        end
        avail = mq.size();
        free  = DEPTH - avail;
        nr = 0;
        for (int p = 0; p < 4; p++) begin
            if (re[p]) begin
                if (nr < avail) begin
                    m_dout[p] = mq[nr];
                    m_rv[p]   = 1'b1;
                    nr++;
                end else begin
                    m_rf[p] = 1'b1;
                end
            end
        end
        for (int unsigned k = 0; k < nr; k++) void'(mq.pop_front());
        nw = 0;
        for (int p = 0; p < 4; p++) begin
            if (we[p]) begin
                if (nw < free) begin
                    mq.push_back(dw[p]);
                    nw++;
                end else begin
                    m_wf[p] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [2:0] model_flags();
        int unsigned n;
        n = mq.size();
        return {n == DEPTH, n >= 4, n == 0};
    endfunction

    initial begin
        srst = 1'b1; wr_en = '0; rd_en = '0; din = '0;
        m_dout = '0; m_rv = '0; m_rf = '0; m_wf = '0;

        //   rst we       din           re       ewf      erv      erf      edout         cnt flags
        add(1, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 0, 3'b001);
        add(0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 0, 3'b001);
        add(0, 4'b1011, 32'hA3EEA1A0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 3, 3'b000);
        add(0, 4'b0000, 32'h0,        4'b1111, 4'b0000, 4'b0111, 4'b1000, 32'h00A3A1A0, 0, 3'b001);
        add(0, 4'b1111, 32'hC3C2C1C0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00A3A1A0, 4, 3'b010);
        add(0, 4'b0001, 32'h000000C4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00A3A1A0, 5, 3'b010);
        add(0, 4'b1111, 32'hD3D2D1D0, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 32'h00A3A1A0, 6, 3'b110);
        add(0, 4'b0001, 32'h000000D9, 4'b0011, 4'b0001, 4'b0011, 4'b0000, 32'h00A3C1C0, 4, 3'b010);
        add(0, 4'b0000, 32'h0,        4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hD0C4C3C2, 0, 3'b001);
        add(0, 4'b0100, 32'h11E02233, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'hD0C4C3C2, 1, 3'b000);
        add(0, 4'b0000, 32'h0,        4'b0100, 4'b0000, 4'b0100, 4'b0000, 32'hD0E0C3C2, 0, 3'b001);
        add(0, 4'b1111, 32'hB3B2B1B0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'hD0E0C3C2, 4, 3'b010);
        add(0, 4'b0000, 32'h0,        4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hB3B2B1B0, 0, 3'b001);
        add(0, 4'b0001, 32'h000000F0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'hB3B2B1B0, 1, 3'b000);
        add(0, 4'b0011, 32'h0000F2F1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'hB3B2B1B0, 3, 3'b000);
        add(1, 4'b1111, 32'h99999999, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 0, 3'b001);
        add(0, 4'b0000, 32'h0,        4'b1111, 4'b0000, 4'b0000, 4'b1111, 32'h00000000, 0, 3'b001);
        add(0, 4'b0001, 32'h0000005A, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1, 3'b000);
        add(0, 4'b0000, 32'h0,        4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0000005A, 0, 3'b001);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].we, tv[i].d, tv[i].re);
            check_outputs($sformatf("vec%0d", i), tv[i].e_wf, tv[i].e_rv, tv[i].e_rf,
                          tv[i].e_dout, tv[i].e_cnt, tv[i].e_flags);
        end

        model_step(1'b1, '0, '0, '0);
        drive(1'b1, '0, '0, '0);
        check_outputs("rnd_reset", m_wf, m_rv, m_rf, m_dout, 3'(mq.size()), model_flags());

        for (int c = 0; c < 2000; c++) begin
            logic [3:0]  we, re;
            logic [31:0] d;
            logic        r;
            int unsigned wp, rp;
            case ((c / 97) % 3)
                0:       begin wp = 75; rp = 25; end
                1:       begin wp = 25; rp = 75; end
                default: begin wp = 50; rp = 50; end
            endcase
            for (int p = 0; p < 4; p++) begin
                we[p] = ($urandom_range(0, 99) < wp);
                re[p] = ($urandom_range(0, 99) < rp);
            end
            d = $urandom();
            r = ($urandom_range(0, 149) == 0);
            model_step(r, we, d, re);
            drive(r, we, d, re);
            check_outputs($sformatf("rnd%0d", c), m_wf, m_rv, m_rf, m_dout,
                          3'(mq.size()), model_flags());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mport_fifo.md
# mport_fifo

Parametrised multi-port synchronous FIFO: up to 8 write ports and 8 read ports per cycle over one circular buffer, with strict port-index ordering and per-port fail reporting. It replaces the single-port fifo wherever a producer or consumer moves several words per cycle, e.g. between superscalar issue slots and a shared queue. RAM is inferred as registers or distributed LUT-RAM; it is not intended for block RAM.

## Interface
- WIDTH, default 32: data word width.
- DEPTH, default 16: number of entries, 2..256. Need not be a power of two.
- WR_PORTS, default 2: write ports, 1..8.
- RD_PORTS, default 2: read ports, 1..8.
- AFULL_LVL, default DEPTH-2: almost_full asserts when data_count >= AFULL_LVL.
- clk  in  1  clock; all logic is on the rising edge.
- srst  in  1  reset, synchronous, active-high.
- din  in  [WR_PORTS][WIDTH]  write data, one word per port.
- wr_en  in  [WR_PORTS]  per-port write request.
- wr_fail  out  [WR_PORTS]  registered; the request on this port last cycle was rejected.
- rd_en  in  [RD_PORTS]  per-port read request.
- dout  out  [RD_PORTS][WIDTH]  registered read data.
- rd_valid  out  [RD_PORTS]  dout[i] holds a word granted last cycle.
- rd_fail  out  [RD_PORTS]  registered; the request on this port last cycle was rejected.
- full, empty, almost_full  out  1  status derived from data_count.
- data_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits; count register, $clog2(DEPTH+1) bits. data_count = count, not a pointer difference.
- Capacities are sampled at the start of the cycle:
  - free = DEPTH - count; avail = count.
  - A read does not free space for a same-cycle write.
  - A write is not visible to a same-cycle read. There is no bypass.
- Write grant:
  - nw = popcount(wr_en); acc_w = min(nw, free).
  - Asserted ports are ranked in ascending index. Rank k < acc_w is granted and writes din to RAM[(wr_ptr+k) mod DEPTH].
  - Asserted ports with rank >= acc_w fail.
  - Deasserted ports neither write nor fail.
- Read grant works the same way with nr = popcount(rd_en) and acc_r = min(nr, avail). Rank k reads RAM[(rd_ptr+k) mod DEPTH] into dout[port].
- Update:
  - wr_ptr += acc_w mod DEPTH; rd_ptr += acc_r mod DEPTH.
  - count += acc_w - acc_r. Compute in $clog2(DEPTH+1)+1 bits; the result never underflows or overflows.
- Modular add: sum = ptr + k, computed one bit wider; if sum >= DEPTH, subtract DEPTH. This is correct for non-power-of-two DEPTH.
- Ungranted read ports: dout[i] holds its previous value, rd_valid[i]=0.
- Status: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_LVL).
- Reset:
  - Pointers and count go to 0.
  - dout goes to all 0; rd_valid, wr_fail and rd_fail go to 0.
  - empty=1, full=0, almost_full = (AFULL_LVL==0).
  - RAM contents are not reset.
- srst wins over any same-cycle request. Requests in a reset cycle are dropped and produce no fail flags.
- Reset mid-stream discards all stored data.

## Timing
- Write: data is accepted at edge N. It is readable by a request presented in cycle N+1, and dout is valid after edge N+1. Minimum write-to-dout is 2 edges.
- Read latency is 1 cycle: request in cycle N gives dout/rd_valid/rd_fail after edge N.
- wr_fail follows request cycle N after edge N.
- Status outputs and data_count reflect the count after the last edge. They are registered-derived, so there is no combinational path from wr_en or rd_en.
- Full throughput: WR_PORTS writes and RD_PORTS reads per cycle, sustained while capacity allows.

## Structure
- Package mport_fifo_pkg:
  - MAX_PORTS=8.
  - Function popcount8.
  - Function wrap_add(ptr, k, depth).
- Sub-module mport_fifo_alloc #(PORTS, CW):
  - Inputs: req[PORTS], capacity (CW bits).
  - Outputs: grant[PORTS], fail[PORTS], rank[PORTS][3], acc count.
  - Implemented as a prefix popcount.
  - Instantiated once for the write side and once for the read side.
- Top level holds the RAM, pointers, count, output registers and wrap arithmetic.

## Test plan
All cases use WIDTH=8, DEPTH=6, WR_PORTS=4, RD_PORTS=4.
- Reset then idle -> empty=1, data_count=0, all rd_valid/fails 0, dout=0.
- Cycle 1: wr_en=1011, din={p0=A0,p1=A1,p3=A3}. Cycle 2: rd_en=1111 -> next cycle rd_valid=0111, dout0..2=A0,A1,A3, rd_fail=1000, data_count=0.
- Fill to count=5, then wr_en=1111 -> only port 0 writes; wr_fail=1110; full=1; almost_full=1 from count>=4.
- Wrap-around: advance the pointers to 4 by writing 4 words and reading 4. Then write 4 words B0..B3 and read 4 -> data returns B0..B3 in order across the index 5->0 wrap.
- At count=6, assert wr_en=0001 and rd_en=0011 in the same cycle -> the write fails (free=0), 2 reads succeed, data_count=4.
- srst asserted with wr_en=1111 and rd_en=1111 at count=3 -> next cycle count=0, no fails, no rd_valid. Old data is not returned afterwards.
